// File: rtl/beam_guard_pkg.sv
// Package: beam_guard_pkg
// Purpose: Types and default timing constants that the beam input conditioner
//          shares with the guard's pre/post quiet-time trigger FSM.
// Contents:
//   beam_state_e      3-bit encoding of the input conditioner FSM states
//   DEF_*             default synchronizer depth, qualification lengths,
//                     pulse-width counter width and stuck-high threshold
//   GLITCH_W          width of the saturating glitch counter
package beam_guard_pkg;

  typedef enum logic [2:0] {
    ST_IDLE_LOW  = 3'd0,  // beam_clean low, waiting for a high sample
    ST_QUAL_HIGH = 3'd1,  // counting consecutive high samples
    ST_HIGH      = 3'd2,  // beam_clean high, measuring width
    ST_QUAL_LOW  = 3'd3,  // beam_clean still high, counting low samples
    ST_STUCK     = 3'd4   // pulse exceeded MAX_HIGH, held high
  } beam_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_MIN_HIGH    = 3;
  localparam int DEF_MIN_LOW     = 3;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_MAX_HIGH    = 200;
  localparam int GLITCH_W        = 16;

endpackage

// File: rtl/beam_sync.sv
// Module: beam_sync
// Purpose: Multi-flop synchronizer bringing the asynchronous beam detector
//          level into the pll_clk domain.
// Ports:
//   pll_clk  in  clock
//   reset    in  synchronous, active-high; clears the chain to 0
//   async_i  in  asynchronous level
//   sync_o   out level after STAGES flops
module beam_sync #(
  parameter int STAGES = 2
) (
  input  logic pll_clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; the reset branch lives inside the
  // clocked block because this codebase resets synchronously.
  always_ff @(posedge pll_clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/beam_input_conditioner.sv
// Module: beam_input_conditioner
// Purpose: Front-end of the beam guard. Synchronizes the raw detector level,
//          rejects short high/low glitches and drives the clean level used by
//          the guard trigger FSM, plus edge strobes, last pulse width, a
//          saturating glitch counter and a sticky stuck-high alarm.
// Ports:
//   pll_clk       in   clock
//   reset         in   synchronous, active-high
//   beam_raw      in   asynchronous raw beam detector level
//   enable        in   1 = new pulses may qualify (pulse in progress completes)
//   clear_status  in   1-cycle clear of stuck_high and glitch_count
//   beam_clean    out  filtered beam level
//   rise_pulse    out  1-cycle strobe on beam_clean 0->1
//   fall_pulse    out  1-cycle strobe on beam_clean 1->0
//   pulse_width   out  width in cycles of last completed non-stuck pulse
//   width_valid   out  1-cycle strobe, pulse_width updated
//   stuck_high    out  sticky alarm, pulse reached MAX_HIGH cycles
//   glitch_count  out  rejected glitches, saturating
module beam_input_conditioner
  import beam_guard_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int MIN_HIGH    = DEF_MIN_HIGH,
  parameter int MIN_LOW     = DEF_MIN_LOW,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MAX_HIGH    = DEF_MAX_HIGH
) (
  input  logic                pll_clk,
  input  logic                reset,
  input  logic                beam_raw,
  input  logic                enable,
  input  logic                clear_status,
  output logic                beam_clean,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [CNT_W-1:0]    pulse_width,
  output logic                width_valid,
  output logic                stuck_high,
  output logic [GLITCH_W-1:0] glitch_count
);

  localparam int QMAX = (MIN_HIGH > MIN_LOW) ? MIN_HIGH : MIN_LOW;
  localparam int QW   = $clog2(QMAX + 1);

  localparam logic [QW-1:0]       QUAL_ONE   = QW'(1);
  localparam logic [QW-1:0]       MIN_HIGH_Q = QW'(MIN_HIGH);
  localparam logic [QW-1:0]       MIN_LOW_Q  = QW'(MIN_LOW);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]    MIN_HIGH_W = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0]    MAX_HIGH_W = CNT_W'(MAX_HIGH);
  localparam logic [GLITCH_W-1:0] GLT_ONE    = GLITCH_W'(1);
  localparam logic [GLITCH_W-1:0] GLT_MAX    = '1;

  logic s;

  beam_state_e         state_q, state_d;
  logic [QW-1:0]       qual_q, qual_d;
  logic [CNT_W-1:0]    width_q, width_d;
  logic                stuck_flag_q, stuck_flag_d;
  logic                beam_clean_q, beam_clean_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic [CNT_W-1:0]    pulse_width_q, pulse_width_d;
  logic                width_valid_q, width_valid_d;
  logic                stuck_high_q, stuck_high_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;

  logic                stuck_set;
  logic                glitch_inc;
  logic [QW-1:0]       qual_inc;
  logic [CNT_W-1:0]    width_inc;
  logic [CNT_W:0]      merge_sum;
  logic [CNT_W-1:0]    width_merge;

  beam_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .pll_clk (pll_clk),
    .reset   (reset),
    .async_i (beam_raw),
    .sync_o  (s)
  );

  // Saturating helpers. A low gap that ends up rejected is folded into the
  // pulse, so the merge adds the low samples seen plus the current high one.
  always_comb begin
    qual_inc    = qual_q + QUAL_ONE;
    width_inc   = (width_q == CNT_MAX) ? width_q : width_q + CNT_ONE;
    merge_sum   = {1'b0, width_q} + (CNT_W + 1)'(qual_inc);
    width_merge = merge_sum[CNT_W] ? CNT_MAX : merge_sum[CNT_W-1:0];
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    qual_d        = qual_q;
    width_d       = width_q;
    stuck_flag_d  = stuck_flag_q;
    beam_clean_d  = beam_clean_q;
    rise_d        = 1'b0;
    fall_d        = 1'b0;
    width_valid_d = 1'b0;
    pulse_width_d = pulse_width_q;
    stuck_set     = 1'b0;
    glitch_inc    = 1'b0;

    unique case (state_q)
      ST_IDLE_LOW: begin
        beam_clean_d = 1'b0;
        if (s && enable) begin
          state_d = ST_QUAL_HIGH;
          qual_d  = QUAL_ONE;
        end
      end

      ST_QUAL_HIGH: begin
        if (!s) begin
          state_d    = ST_IDLE_LOW;
          glitch_inc = 1'b1;
        end else if (qual_inc == MIN_HIGH_Q) begin
          state_d      = ST_HIGH;
          beam_clean_d = 1'b1;
          rise_d       = 1'b1;
          width_d      = MIN_HIGH_W;
          stuck_flag_d = 1'b0;
        end else begin
          qual_d = qual_inc;
        end
      end

      ST_HIGH: begin
        if (s) begin
          width_d = width_inc;
          if (width_inc >= MAX_HIGH_W) begin
            state_d      = ST_STUCK;
            stuck_set    = 1'b1;
            stuck_flag_d = 1'b1;
          end
        end else begin
          state_d = ST_QUAL_LOW;
          qual_d  = QUAL_ONE;
        end
      end

      ST_QUAL_LOW: begin
        if (s) begin
          // Low gap too short: rejoin the pulse it interrupted.
          glitch_inc = 1'b1;
          width_d    = width_merge;
          state_d    = stuck_flag_q ? ST_STUCK : ST_HIGH;
        end else if (qual_inc == MIN_LOW_Q) begin
          state_d      = ST_IDLE_LOW;
          beam_clean_d = 1'b0;
          fall_d       = 1'b1;
          stuck_flag_d = 1'b0;
          // A stuck pulse has no meaningful width, so it is not reported.
          if (!stuck_flag_q) begin
            width_valid_d = 1'b1;
            pulse_width_d = width_q;
          end
        end else begin
          qual_d = qual_inc;
        end
      end

      ST_STUCK: begin
        if (!s) begin
          state_d = ST_QUAL_LOW;
          qual_d  = QUAL_ONE;
        end
      end

      default: begin
        state_d      = ST_IDLE_LOW;
        beam_clean_d = 1'b0;
      end
    endcase
  end

  // Status registers. A new stuck event outranks a clear in the same cycle so
  // the alarm is never lost; for the glitch counter the clear wins.
  always_comb begin
    stuck_high_d = stuck_high_q;
    if (stuck_set) begin
      stuck_high_d = 1'b1;
    end else if (clear_status) begin
      stuck_high_d = 1'b0;
    end

    glitch_d = glitch_q;
    if (clear_status) begin
      glitch_d = '0;
    end else if (glitch_inc && (glitch_q != GLT_MAX)) begin
      glitch_d = glitch_q + GLT_ONE;
    end
  end

  always_ff @(posedge pll_clk) begin
    if (reset) begin
      state_q       <= ST_IDLE_LOW;
      qual_q        <= '0;
      width_q       <= '0;
      stuck_flag_q  <= 1'b0;
      beam_clean_q  <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      pulse_width_q <= '0;
      width_valid_q <= 1'b0;
      stuck_high_q  <= 1'b0;
      glitch_q      <= '0;
    end else begin
      state_q       <= state_d;
      qual_q        <= qual_d;
      width_q       <= width_d;
      stuck_flag_q  <= stuck_flag_d;
      beam_clean_q  <= beam_clean_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      pulse_width_q <= pulse_width_d;
      width_valid_q <= width_valid_d;
      stuck_high_q  <= stuck_high_d;
      glitch_q      <= glitch_d;
    end
  end

  assign beam_clean   = beam_clean_q;
  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign pulse_width  = pulse_width_q;
  assign width_valid  = width_valid_q;
  assign stuck_high   = stuck_high_q;
  assign glitch_count = glitch_q;

endmodule

// File: tb/tb_beam_input_conditioner.sv
// Testbench: tb_beam_input_conditioner
// Purpose: Directed stimulus for beam_input_conditioner with default
//          parameters. Stimulus pushes the expected strobe events (cycle of
//          occurrence and, for width_valid, the width) into a queue; a monitor
//          on the falling edge pops and compares whenever the DUT strobes.
//          Status outputs are checked directly at quiet points.
module tb_beam_input_conditioner;
  import beam_guard_pkg::*;

  localparam int CNT_W = 8;

  logic                pll_clk = 1'b0;
  logic                reset = 1'b1;
  logic                beam_raw = 1'b0;
  logic                enable = 1'b1;
  logic                clear_status = 1'b0;
  logic                beam_clean;
  logic                rise_pulse;
  logic                fall_pulse;
  logic [CNT_W-1:0]    pulse_width;
  logic                width_valid;
  logic                stuck_high;
  logic [GLITCH_W-1:0] glitch_count;

  typedef enum int {EV_RISE, EV_FALL, EV_WIDTH, EV_STUCK} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    int       val;
  } ev_t;

  ev_t  exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   exp_glitch = 0;
  logic stuck_prev = 1'b0;

  beam_input_conditioner #(
    .SYNC_STAGES (2),
    .MIN_HIGH    (3),
    .MIN_LOW     (3),
    .CNT_W       (CNT_W),
    .MAX_HIGH    (200)
  ) dut (
    .pll_clk      (pll_clk),
    .reset        (reset),
    .beam_raw     (beam_raw),
    .enable       (enable),
    .clear_status (clear_status),
    .beam_clean   (beam_clean),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .pulse_width  (pulse_width),
    .width_valid  (width_valid),
    .stuck_high   (stuck_high),
    .glitch_count (glitch_count)
  );

  always #5 pll_clk = ~pll_clk;

  // cyc = number of rising edges so far.
  always @(posedge pll_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic push(input ev_kind_t k, input int c, input int v);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic match_event(input ev_kind_t k, input int v);
    ev_t e;
    if (exp_q.size() == 0) begin
      check($sformatf("%s_expected", k.name()), exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("%s_kind", k.name()), int'(k), int'(e.kind));
      check($sformatf("%s_cycle", k.name()), cyc, e.cyc);
      if (k == EV_WIDTH) check("pulse_width", v, e.val);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge pll_clk) begin
    if (rise_pulse) match_event(EV_RISE, 0);
    if (stuck_high && !stuck_prev) match_event(EV_STUCK, 0);
    if (fall_pulse) match_event(EV_FALL, 0);
    if (width_valid) match_event(EV_WIDTH, int'(pulse_width));
    stuck_prev <= stuck_high;
  end

  // Leaves the caller 1 time unit after the n-th rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge pll_clk);
    #1;
  endtask

  // Raw high for hi sampling edges, then low.
  task automatic raw_pulse(input int hi);
    beam_raw = 1'b1;
    tick(hi);
    beam_raw = 1'b0;
  endtask

  task automatic settle(input string name);
    tick(12);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_clean_low"}, int'(beam_clean), 0);
    check({name, "_glitches"}, int'(glitch_count), exp_glitch);
  endtask

  initial begin
    int t0;
    int rr;

    // Reset state.
    tick(3);
    check("rst_beam_clean", int'(beam_clean), 0);
    check("rst_rise", int'(rise_pulse), 0);
    check("rst_fall", int'(fall_pulse), 0);
    check("rst_width_valid", int'(width_valid), 0);
    check("rst_pulse_width", int'(pulse_width), 0);
    check("rst_stuck", int'(stuck_high), 0);
    check("rst_glitch", int'(glitch_count), 0);
    reset = 1'b0;
    tick(2);

    // Clean 10-cycle pulse: rises 5 edges after raw, 10 cycles wide.
    t0 = cyc;
    push(EV_RISE, t0 + 5, 0);
    push(EV_FALL, t0 + 15, 0);
    push(EV_WIDTH, t0 + 15, 10);
    raw_pulse(10);
    settle("p10");

    // 2-cycle and 1-cycle high glitches are rejected.
    raw_pulse(2);
    exp_glitch++;
    settle("g2");
    raw_pulse(1);
    exp_glitch++;
    settle("g1");

    // Exactly MIN_HIGH cycles qualifies.
    t0 = cyc;
    push(EV_RISE, t0 + 5, 0);
    push(EV_FALL, t0 + 8, 0);
    push(EV_WIDTH, t0 + 8, 3);
    raw_pulse(3);
    settle("p3");

    // 8 high / 1 low / 6 high merges into one 15-cycle pulse.
    t0 = cyc;
    push(EV_RISE, t0 + 5, 0);
    push(EV_FALL, t0 + 20, 0);
    push(EV_WIDTH, t0 + 20, 15);
    raw_pulse(8);
    tick(1);
    raw_pulse(6);
    exp_glitch++;
    settle("m816");

    // 5 high / 2 low / 5 high: gap one short of MIN_LOW, merged to 12.
    t0 = cyc;
    push(EV_RISE, t0 + 5, 0);
    push(EV_FALL, t0 + 17, 0);
    push(EV_WIDTH, t0 + 17, 12);
    raw_pulse(5);
    tick(2);
    raw_pulse(5);
    exp_glitch++;
    settle("m525");

    // 5 high / 3 low / 5 high: gap of exactly MIN_LOW splits into two pulses.
    t0 = cyc;
    push(EV_RISE, t0 + 5, 0);
    push(EV_FALL, t0 + 10, 0);
    push(EV_WIDTH, t0 + 10, 5);
    push(EV_RISE, t0 + 13, 0);
    push(EV_FALL, t0 + 18, 0);
    push(EV_WIDTH, t0 + 18, 5);
    raw_pulse(5);
    tick(3);
    raw_pulse(5);
    settle("s535");

    // enable=0 blocks qualification entirely.
    enable = 1'b0;
    raw_pulse(10);
    settle("dis");
    enable = 1'b1;

    // clear_status alone clears the glitch counter.
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    exp_glitch = 0;
    check("clr_glitch", int'(glitch_count), 0);
    raw_pulse(1);
    exp_glitch = 1;
    settle("g1b");

    // 1-cycle glitch increments on edge t0+4; clear on that same edge wins.
    t0 = cyc;
    raw_pulse(1);
    tick(2);
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    exp_glitch = 0;
    settle("clr_same");

    // 250-cycle pulse: stuck at width 200, fall without width_valid.
    t0 = cyc;
    push(EV_RISE, t0 + 5, 0);
    push(EV_STUCK, t0 + 202, 0);
    push(EV_FALL, t0 + 255, 0);
    raw_pulse(250);
    check("stuck_during", int'(stuck_high), 1);
    check("stuck_clean_high", int'(beam_clean), 1);
    settle("stuck");
    check("stuck_sticky", int'(stuck_high), 1);
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    check("stuck_cleared", int'(stuck_high), 0);

    // Reset mid-pulse with a non-zero glitch count.
    raw_pulse(1);
    exp_glitch = 1;
    settle("g1c");
    t0 = cyc;
    push(EV_RISE, t0 + 5, 0);
    beam_raw = 1'b1;
    tick(8);
    check("pre_rst_clean", int'(beam_clean), 1);
    reset = 1'b1;
    tick(1);
    check("mid_rst_clean", int'(beam_clean), 0);
    check("mid_rst_fall", int'(fall_pulse), 0);
    check("mid_rst_wvalid", int'(width_valid), 0);
    check("mid_rst_glitch", int'(glitch_count), 0);
    exp_glitch = 0;
    tick(1);
    reset = 1'b0;
    rr = cyc;
    push(EV_RISE, rr + 5, 0);
    push(EV_FALL, rr + 12, 0);
    push(EV_WIDTH, rr + 12, 7);
    tick(7);
    beam_raw = 1'b0;
    settle("rst_mid");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
